perf_monitor: RTL and testbench
===============================

Name: perf_monitor

Overview:
- Hardware performance monitor sitting downstream of the 5-stage pipelined CPU core.
- Consumes the core's per-cycle status: start, hazard stall, branch/jump flush, writeback retire, and PC.
- Keeps cycle, stall, flush and retired-instruction counts, and asserts a halt after a programmable cycle budget.
- Exposes everything through a registered read port, so benches and debug logic no longer reach into core internals.

Parameters:
- CNT_W, 32: width of every counter and of rd_data_o.
- MAX_CYCLES, 30: cycles counted in RUN before entering HALT; 0 disables the budget.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  core start; level-sensitive run enable.
- clear_i  in  1  synchronous clear of counters and trace; state forced to IDLE.
- stall_i  in  1  hazard unit requests a stall (PC/IF-ID hold) this cycle.
- flush_i  in  1  IF/ID flush this cycle (taken branch or jump).
- retire_i  in  1  valid, non-bubble instruction in WB this cycle.
- pc_i  in  32  current PC register value.
- sel_i  in  4  readout select.
- rd_data_o  out  CNT_W  registered readout.
- running_o  out  1  state == RUN.
- halt_o  out  1  state == HALT.

Behaviour:
- Reset (rst_i=1 at an edge) takes priority over everything:
  - all counters 0, state IDLE, rd_data_o 0, running_o 0, halt_o 0;
  - trace cleared and its pointer set to 0.
- clear_i has next priority: same effect as reset, except rd_data_o still updates normally.
- State machine, 2-bit encoding IDLE=0, RUN=1, HALT=2:
  - IDLE -> RUN when start_i=1.
  - RUN -> IDLE when start_i=0; this is a pause and counters hold.
  - RUN -> HALT on the edge where the cycle counter becomes MAX_CYCLES (MAX_CYCLES != 0).
  - HALT is sticky; only rst_i or clear_i leaves it.
- Counting happens only in RUN, including the cycle that transitions to HALT:
  - cycle_cnt +1 every RUN cycle;
  - stall_cnt +1 when stall_i=1 and flush_i=0;
  - flush_cnt +1 when flush_i=1, so simultaneous stall and flush counts as a flush only;
  - retire_cnt +1 when retire_i=1.
- Counters saturate at all-ones; they never wrap.
- Inputs are ignored in IDLE and HALT.
- The first RUN cycle is the edge after start_i rises. Counting therefore begins one cycle after the IDLE->RUN edge.
- Readout has latency 1: rd_data_o on the edge after sel_i is presented reflects values after that edge's update. It updates in every state.
- sel_i map:
  - 0 cycle_cnt; 1 stall_cnt; 2 flush_cnt; 3 retire_cnt;
  - 4 status = {zero-pad, halt, running, state[1:0]};
  - 5 pc_i snapshot taken at the HALT transition (0 before any halt);
  - 8..11 flush trace, when enabled;
  - every other value reads 0.
- running_o and halt_o are registered; they match the state register.

Optional Feature:
- Macro PERF_FLUSH_TRACE_EN.
- Defined:
  - 4-entry circular buffer; on each counted flush, pc_i is written at the write pointer and the pointer advances mod 4, overwriting the oldest entry.
  - sel_i 8 returns the newest entry, 9 the next older, through 11 the oldest.
  - Unwritten entries read 0.
- Undefined: no buffer or pointer is generated, and sel_i 8..11 read 0.

Decomposition:
- Shared package perf_pkg holds:
  - state encodings PERF_IDLE/PERF_RUN/PERF_HALT;
  - sel_i codes PERF_SEL_CYCLE, PERF_SEL_STALL, PERF_SEL_FLUSH, PERF_SEL_RETIRE, PERF_SEL_STATUS, PERF_SEL_HALTPC, PERF_SEL_TRACE0;
  - trace depth constant PERF_TRACE_DEPTH=4.
- One sub-module, perf_sat_counter: CNT_W saturating counter with clear and increment-enable, instantiated 4 times.

Test Plan:
- Reset, then start_i=1, all events 0 for 30 cycles -> cycle_cnt=30, halt_o=1 on the edge where the count reaches 30, and further cycles leave cycle_cnt at 30.
- In RUN, pulse stall_i for 3 cycles, then stall_i=flush_i=1 for 1 cycle -> stall_cnt=3, flush_cnt=1.
- Drop start_i for 5 cycles mid-run at cycle_cnt=10 -> state IDLE, cycle_cnt stays 10, counting resumes on restart.
- CNT_W=4, MAX_CYCLES=0, run 20 cycles -> cycle_cnt saturates at 15.
- With PERF_FLUSH_TRACE_EN, flushes at pc_i=0x8,0x14,0x20,0x2C,0x38 -> sel 8..11 read 0x38,0x2C,0x20,0x14.
- Assert rst_i and then clear_i while in HALT -> both return to IDLE with all counts 0; rd_data_o reads 0 one cycle after reset.

Source files
------------

// File: rtl/perf_pkg.sv
// -----------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the performance monitor:
//   - perf_state_e      : monitor state encoding (IDLE=0, RUN=1, HALT=2)
//   - PERF_SEL_*        : readout select codes for sel_i
//   - PERF_TRACE_DEPTH  : number of entries in the optional flush trace
// -----------------------------------------------------------------------------
package perf_pkg;

    typedef enum logic [1:0] {
        PERF_IDLE = 2'd0,
        PERF_RUN  = 2'd1,
        PERF_HALT = 2'd2
    } perf_state_e;

    localparam logic [3:0] PERF_SEL_CYCLE  = 4'd0;
    localparam logic [3:0] PERF_SEL_STALL  = 4'd1;
    localparam logic [3:0] PERF_SEL_FLUSH  = 4'd2;
    localparam logic [3:0] PERF_SEL_RETIRE = 4'd3;
    localparam logic [3:0] PERF_SEL_STATUS = 4'd4;
    localparam logic [3:0] PERF_SEL_HALTPC = 4'd5;
    // Trace entries occupy PERF_SEL_TRACE0 .. PERF_SEL_TRACE0 + depth - 1.
    localparam logic [3:0] PERF_SEL_TRACE0 = 4'd8;

    localparam int PERF_TRACE_DEPTH = 4;
    localparam int PERF_TRACE_PTR_W = $clog2(PERF_TRACE_DEPTH);

endpackage

// File: rtl/perf_sat_counter.sv
// -----------------------------------------------------------------------------
// perf_sat_counter
// CNT_W-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk_i     in   clock
//   rst_i     in   synchronous active-high reset (count -> 0)
//   clr_i     in   synchronous clear (count -> 0), overrides inc_i
//   inc_i     in   increment enable for this cycle
//   cnt_nxt_o out  value the counter holds after the coming edge; the top
//                  uses it both for the registered readout and for the
//                  cycle-budget compare, which act on post-edge values
// -----------------------------------------------------------------------------
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_nxt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves cnt_d
        // unassigned; otherwise synthesis infers a latch.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/perf_monitor.sv
// -----------------------------------------------------------------------------
// perf_monitor
// Performance monitor for the 5-stage pipelined core. Counts cycles, stalls,
// flushes and retired instructions while running, halts after a cycle budget
// and exposes everything through a registered, select-addressed read port.
//
// Optional feature macro: PERF_FLUSH_TRACE_EN
//   defined   : 4-entry circular trace of the PCs of counted flushes,
//               readable at sel_i 8 (newest) .. 11 (oldest)
//   undefined : no trace storage; sel_i 8..11 read 0
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous active-high reset, highest priority
//   start_i    in   level-sensitive run enable
//   clear_i    in   synchronous clear of counters/trace/state
//   stall_i    in   hazard stall this cycle
//   flush_i    in   IF/ID flush this cycle
//   retire_i   in   valid instruction in WB this cycle
//   pc_i       in   current PC
//   sel_i      in   readout select
//   rd_data_o  out  registered readout (latency 1)
//   running_o  out  state == RUN (registered)
//   halt_o     out  state == HALT (registered)
// -----------------------------------------------------------------------------
module perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic [31:0]      pc_i,
    input  logic [3:0]       sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             running_o,
    output logic             halt_o
);

    localparam bit               BUDGET_EN = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] BUDGET    = CNT_W'(MAX_CYCLES);

    perf_state_e      state_q, state_d;
    logic             running_q, running_d;
    logic             halt_q, halt_d;
    logic [31:0]      halt_pc_q, halt_pc_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic             in_run;
    logic [CNT_W-1:0] cycle_nxt, stall_nxt, flush_nxt, retire_nxt;
    logic [31:0]      trace_rd;

    // Events are only observed while the registered state is RUN, which
    // includes the edge that leaves RUN (pause or budget expiry).
    assign in_run = (state_q == PERF_RUN);

    perf_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i),
        .inc_i(in_run), .cnt_nxt_o(cycle_nxt)
    );

    // A simultaneous stall and flush is attributed to the flush only.
    perf_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i),
        .inc_i(in_run && stall_i && !flush_i), .cnt_nxt_o(stall_nxt)
    );

    perf_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i),
        .inc_i(in_run && flush_i), .cnt_nxt_o(flush_nxt)
    );

    perf_sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i),
        .inc_i(in_run && retire_i), .cnt_nxt_o(retire_nxt)
    );

    // State machine and halt-PC snapshot.
    always_comb begin
        state_d   = state_q;
        halt_pc_d = halt_pc_q;
        if (clear_i) begin
            state_d   = PERF_IDLE;
            halt_pc_d = '0;
        end else begin
            case (state_q)
                PERF_IDLE: if (start_i) state_d = PERF_RUN;
                PERF_RUN: begin
                    // Budget expiry wins over a simultaneous pause.
                    if (BUDGET_EN && (cycle_nxt == BUDGET)) begin
                        state_d   = PERF_HALT;
                        halt_pc_d = pc_i;
                    end else if (!start_i) begin
                        state_d = PERF_IDLE;
                    end
                end
                PERF_HALT: state_d = PERF_HALT;
                default:   state_d = PERF_IDLE;
            endcase
        end
        running_d = (state_d == PERF_RUN);
        halt_d    = (state_d == PERF_HALT);
    end

`ifdef PERF_FLUSH_TRACE_EN
    logic [31:0]                 trace_q [PERF_TRACE_DEPTH];
    logic [31:0]                 trace_d [PERF_TRACE_DEPTH];
    logic [PERF_TRACE_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PERF_TRACE_PTR_W-1:0] rd_idx;

    always_comb begin
        trace_d  = trace_q;
        wr_ptr_d = wr_ptr_q;
        if (clear_i) begin
            for (int i = 0; i < PERF_TRACE_DEPTH; i++) trace_d[i] = '0;
            wr_ptr_d = '0;
        end else if (in_run && flush_i) begin
            trace_d[wr_ptr_q] = pc_i;
            wr_ptr_d          = wr_ptr_q + PERF_TRACE_PTR_W'(1);
        end
    end

    // Newest entry sits just behind the write pointer; older ones follow.
    assign rd_idx   = wr_ptr_d - PERF_TRACE_PTR_W'(1) - sel_i[PERF_TRACE_PTR_W-1:0];
    assign trace_rd = trace_d[rd_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: this small array is reset on purpose so unwritten entries
            // read 0; large RAMs are normally left unreset.
            for (int i = 0; i < PERF_TRACE_DEPTH; i++) trace_q[i] <= '0;
            wr_ptr_q <= '0;
        end else begin
            trace_q  <= trace_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end
`else
    assign trace_rd = '0;
`endif

    // Readout reflects post-edge values, so it selects from the *_d/nxt side.
    always_comb begin
        rd_data_d = '0;
        case (sel_i)
            PERF_SEL_CYCLE:  rd_data_d = cycle_nxt;
            PERF_SEL_STALL:  rd_data_d = stall_nxt;
            PERF_SEL_FLUSH:  rd_data_d = flush_nxt;
            PERF_SEL_RETIRE: rd_data_d = retire_nxt;
            PERF_SEL_STATUS: rd_data_d = CNT_W'({halt_d, running_d, state_d});
            PERF_SEL_HALTPC: rd_data_d = CNT_W'(halt_pc_d);
            default: begin
                if ((sel_i >= PERF_SEL_TRACE0) &&
                    (sel_i < PERF_SEL_TRACE0 + 4'(PERF_TRACE_DEPTH))) begin
                    rd_data_d = CNT_W'(trace_rd);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= PERF_IDLE;
            running_q <= 1'b0;
            halt_q    <= 1'b0;
            halt_pc_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            halt_q    <= halt_d;
            halt_pc_q <= halt_pc_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign running_o = running_q;
    assign halt_o    = halt_q;

endmodule

// File: tb/tb_perf_monitor.sv
// -----------------------------------------------------------------------------
// tb_perf_monitor
// Directed bench for perf_monitor. DUT a uses the default parameters
// (32-bit counters, 30-cycle budget); DUT b uses 4-bit counters with the
// budget disabled to exercise saturation. Stimulus queues the expected
// post-edge readout; a negedge monitor pops and compares it.
// -----------------------------------------------------------------------------
module tb_perf_monitor;
    import perf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clear, stall, flush, retire;
    logic [31:0] pc;
    logic [3:0]  sel;
    logic [31:0] rd_a;
    logic        run_a, halt_a;

    logic        start_b, clear_b;
    logic [3:0]  sel_b;
    logic [3:0]  rd_b;
    logic        run_b, halt_b;

    perf_monitor u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .stall_i(stall), .flush_i(flush), .retire_i(retire), .pc_i(pc),
        .sel_i(sel), .rd_data_o(rd_a), .running_o(run_a), .halt_o(halt_a)
    );

    perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .clear_i(clear_b),
        .stall_i(stall), .flush_i(flush), .retire_i(retire), .pc_i(pc),
        .sel_i(sel_b), .rd_data_o(rd_b), .running_o(run_b), .halt_o(halt_b)
    );

`ifdef PERF_FLUSH_TRACE_EN
    localparam logic [31:0] TRACE_MASK = '1;
`else
    localparam logic [31:0] TRACE_MASK = '0;
`endif

    typedef struct {
        int          id;
        int          due;
        logic [31:0] val;
        logic        run;
        logic        halt;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: compare every expectation whose edge has just happened.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            if (cur.id == 0) begin
                check(cur.name, rd_a, cur.val);
                check({cur.name, "_flags"}, {30'b0, run_a, halt_a}, {30'b0, cur.run, cur.halt});
            end else begin
                check(cur.name, {28'b0, rd_b}, cur.val);
                check({cur.name, "_flags"}, {30'b0, run_b, halt_b}, {30'b0, cur.run, cur.halt});
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(int id, logic [31:0] v, logic r, logic h, string n);
        exp_t e;
        e.id = id; e.due = cyc + 1; e.val = v; e.run = r; e.halt = h; e.name = n;
        sb.push_back(e);
    endtask

    // Expectations describe the value visible after the coming rising edge.
    task automatic expect_a(logic [3:0] s, logic [31:0] v, logic r, logic h, string n);
        sel = s;
        push(0, v, r, h, n);
    endtask

    task automatic expect_b(logic [3:0] s, logic [31:0] v, logic r, logic h, string n);
        sel_b = s;
        push(1, v, r, h, n);
    endtask

    initial begin
        #200000;
        bad++;
        total++;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; stall = 1'b0; flush = 1'b0;
        retire = 1'b0; pc = '0; sel = '0; start_b = 1'b0; clear_b = 1'b0; sel_b = '0;
        step();

        // Reset state
        expect_a(PERF_SEL_CYCLE, 32'd0, 1'b0, 1'b0, "reset_rd");
        expect_b(PERF_SEL_CYCLE, 32'd0, 1'b0, 1'b0, "b_reset_rd");
        step();
        rst = 1'b0;
        expect_a(PERF_SEL_STATUS, 32'd0, 1'b0, 1'b0, "idle_status");
        step();

        // Cycle budget: 30 counted cycles then HALT
        pc = 32'h400; start = 1'b1;
        expect_a(PERF_SEL_STATUS, 32'd5, 1'b1, 1'b0, "run_status");
        step();
        for (int i = 1; i <= 30; i++) begin
            expect_a(PERF_SEL_CYCLE, 32'(i), (i < 30), (i == 30), $sformatf("budget_cyc%0d", i));
            step();
        end

        // HALT is sticky and ignores events
        pc = 32'h999; stall = 1'b1; flush = 1'b1; retire = 1'b1;
        expect_a(PERF_SEL_CYCLE,  32'd30,   1'b0, 1'b1, "halt_cyc_hold"); step();
        expect_a(PERF_SEL_STALL,  32'd0,    1'b0, 1'b1, "halt_stall");    step();
        expect_a(PERF_SEL_FLUSH,  32'd0,    1'b0, 1'b1, "halt_flush");    step();
        expect_a(PERF_SEL_RETIRE, 32'd0,    1'b0, 1'b1, "halt_retire");   step();
        expect_a(PERF_SEL_STATUS, 32'd10,   1'b0, 1'b1, "halt_status");   step();
        expect_a(PERF_SEL_HALTPC, 32'h400,  1'b0, 1'b1, "halt_pc");       step();
        expect_a(4'd7,            32'd0,    1'b0, 1'b1, "sel7_zero");     step();
        expect_a(4'd15,           32'd0,    1'b0, 1'b1, "sel15_zero");    step();
        expect_a(PERF_SEL_TRACE0, 32'd0,    1'b0, 1'b1, "trace_halt");    step();
        stall = 1'b0; flush = 1'b0; retire = 1'b0;

        // Clear out of HALT
        start = 1'b0; clear = 1'b1;
        expect_a(PERF_SEL_CYCLE, 32'd0, 1'b0, 1'b0, "clear_cyc");
        step();
        clear = 1'b0;
        expect_a(PERF_SEL_HALTPC, 32'd0, 1'b0, 1'b0, "clear_haltpc"); step();
        expect_a(PERF_SEL_STATUS, 32'd0, 1'b0, 1'b0, "clear_status"); step();

        // Stall/flush/retire accounting and flush trace
        start = 1'b1; pc = 32'h0;
        expect_a(PERF_SEL_CYCLE, 32'd0, 1'b1, 1'b0, "start_edge_no_count"); step();
        stall = 1'b1;
        expect_a(PERF_SEL_CYCLE, 32'd1, 1'b1, 1'b0, "ev_cyc1"); step();
        expect_a(PERF_SEL_STALL, 32'd2, 1'b1, 1'b0, "stall2");  step();
        retire = 1'b1;
        expect_a(PERF_SEL_RETIRE, 32'd1, 1'b1, 1'b0, "retire1"); step();
        retire = 1'b0; flush = 1'b1; pc = 32'h8;
        expect_a(PERF_SEL_STALL, 32'd3, 1'b1, 1'b0, "stall_with_flush"); step();
        stall = 1'b0; pc = 32'h14;
        expect_a(PERF_SEL_FLUSH, 32'd2, 1'b1, 1'b0, "flush2"); step();
        pc = 32'h20;
        expect_a(PERF_SEL_CYCLE, 32'd6, 1'b1, 1'b0, "ev_cyc6"); step();
        pc = 32'h2C; retire = 1'b1;
        expect_a(PERF_SEL_RETIRE, 32'd2, 1'b1, 1'b0, "retire2"); step();
        pc = 32'h38; retire = 1'b0;
        expect_a(PERF_SEL_FLUSH, 32'd5, 1'b1, 1'b0, "flush5"); step();
        flush = 1'b0; pc = 32'h50;
        expect_a(PERF_SEL_TRACE0, 32'h38 & TRACE_MASK, 1'b1, 1'b0, "trace_newest"); step();

        // Pause: the edge leaving RUN still counts (cycle 10), then hold
        start = 1'b0;
        expect_a(PERF_SEL_TRACE0 + 4'd1, 32'h2C & TRACE_MASK, 1'b0, 1'b0, "trace_1"); step();
        stall = 1'b1; flush = 1'b1; retire = 1'b1; pc = 32'h60;
        expect_a(PERF_SEL_CYCLE,  32'd10, 1'b0, 1'b0, "pause_cyc");    step();
        expect_a(PERF_SEL_STALL,  32'd3,  1'b0, 1'b0, "pause_stall");  step();
        expect_a(PERF_SEL_FLUSH,  32'd5,  1'b0, 1'b0, "pause_flush");  step();
        expect_a(PERF_SEL_RETIRE, 32'd2,  1'b0, 1'b0, "pause_retire"); step();
        expect_a(PERF_SEL_TRACE0 + 4'd2, 32'h20 & TRACE_MASK, 1'b0, 1'b0, "trace_2"); step();
        stall = 1'b0; flush = 1'b0; retire = 1'b0;

        // Resume
        start = 1'b1;
        expect_a(PERF_SEL_CYCLE, 32'd10, 1'b1, 1'b0, "resume_edge");  step();
        expect_a(PERF_SEL_CYCLE, 32'd11, 1'b1, 1'b0, "resume_count"); step();
        expect_a(PERF_SEL_TRACE0 + 4'd3, 32'h14 & TRACE_MASK, 1'b1, 1'b0, "trace_oldest"); step();
        pc = 32'h40;
        for (int i = 13; i <= 30; i++) begin
            if (i == 30) expect_a(PERF_SEL_HALTPC, 32'h40, 1'b0, 1'b1, "halt_pc_resumed");
            else         expect_a(PERF_SEL_CYCLE, 32'(i), 1'b1, 1'b0, $sformatf("resumed_cyc%0d", i));
            step();
        end

        // Reset out of HALT
        start = 1'b0; rst = 1'b1;
        expect_a(PERF_SEL_RETIRE, 32'd0, 1'b0, 1'b0, "rst_rd");
        step();
        rst = 1'b0;
        expect_a(PERF_SEL_STATUS, 32'd0, 1'b0, 1'b0, "rst_status");      step();
        expect_a(PERF_SEL_TRACE0, 32'd0, 1'b0, 1'b0, "rst_trace_clear"); step();
        expect_a(PERF_SEL_FLUSH,  32'd0, 1'b0, 1'b0, "rst_flush");       step();
        expect_a(PERF_SEL_HALTPC, 32'd0, 1'b0, 1'b0, "rst_haltpc");      step();

        // 4-bit counter saturation with the budget disabled
        start_b = 1'b1;
        expect_b(PERF_SEL_CYCLE, 32'd0, 1'b1, 1'b0, "b_start"); step();
        for (int k = 1; k <= 20; k++) begin
            expect_b(PERF_SEL_CYCLE, (k > 15) ? 32'd15 : 32'(k), 1'b1, 1'b0, $sformatf("b_cyc%0d", k));
            step();
        end
        expect_b(PERF_SEL_STATUS, 32'd5, 1'b1, 1'b0, "b_status"); step();

        step();
        step();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
